// File: rtl/soc_pio_pkg.sv
// Shared definitions for the soc_pio_in_capture input port: register map,
// edge-detection modes and a constant clog2 helper.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Decoded write strobes for the two writable registers.
  typedef struct packed {
    logic irqmask;
    logic edgecap;
  } pio_wr_t;

  // Minimum bit count able to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/soc_pio_debounce.sv
// Single-bit debounce filter: q follows d only after d has disagreed with q
// for DEBOUNCE_CYCLES consecutive clocks.
module soc_pio_debounce
  import soc_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The update happens on the clock where the incremented count would reach
  // DEBOUNCE_CYCLES, so q moves exactly DEBOUNCE_CYCLES clocks after d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/soc_pio_in_capture.sv
// Avalon-MM input port: synchronised level, sticky edge capture and maskable
// interrupt. Optional per-bit debounce is built when SOC_PIO_IN_DEBOUNCE_EN is defined.
module soc_pio_in_capture
  import soc_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam edge_type_e EDGE_KIND = edge_type_e'(EDGE_TYPE);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("soc_pio_in_capture: DATA_WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("soc_pio_in_capture: SYNC_STAGES must be 2..3");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("soc_pio_in_capture: EDGE_TYPE must be 0..2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_dbc
    $error("soc_pio_in_capture: DEBOUNCE_CYCLES must be 1..65535");
  end

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] f;
  logic [DATA_WIDTH-1:0] prev_f;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] w1c;
  logic [31:0]           rd_next;
  pio_wr_t               wr;

  // ---------------------------------------------------------------- input path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the synchroniser is a small flop array, not RAM, so every stage
      // is reset explicitly to keep f at 0 until real samples arrive.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's
      // previous value, giving a true SYNC_STAGES-deep chain.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_debounce
    soc_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .d    (s[i]),
      .q    (f[i])
    );
  end
`else
  assign f = s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_f <= '0;
    else       prev_f <= f;
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    edge_vec = '0;
    case (EDGE_KIND)
      EDGE_RISE: edge_vec = f & ~prev_f;
      EDGE_FALL: edge_vec = ~f & prev_f;
      EDGE_ANY:  edge_vec = f ^ prev_f;
      default:   edge_vec = f & ~prev_f;
    endcase
  end

  // ------------------------------------------------------------- register file
  always_comb begin
    wr         = '0;
    wr.irqmask = chipselect && write && (address == PIO_ADDR_IRQMASK);
    wr.edgecap = chipselect && write && (address == PIO_ADDR_EDGECAP);
  end

  assign w1c = wr.edgecap ? writedata[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
    end else if (wr.irqmask) begin
      irqmask <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Set is OR-ed in after the clear so a same-cycle edge keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) edgecap <= '0;
    else       edgecap <= (edgecap & ~w1c) | edge_vec;
  end

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  if (DATA_WIDTH < 32) begin : g_wdata_hi
    assign unused_wdata = ^writedata[31:DATA_WIDTH];
  end else begin : g_wdata_full
    assign unused_wdata = 1'b0;
  end

  // ------------------------------------------------------------------ read mux
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:    rd_next[DATA_WIDTH-1:0] = f;
      PIO_ADDR_IRQMASK: rd_next[DATA_WIDTH-1:0] = irqmask;
      PIO_ADDR_RSVD:    rd_next = '0;
      PIO_ADDR_EDGECAP: rd_next[DATA_WIDTH-1:0] = edgecap;
      default:          rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_soc_pio_in_capture.sv
// Self-checking bench for soc_pio_in_capture: directed vector table, hand
// timing sequences and randomized traffic against a behavioural model.
module tb_soc_pio_in_capture;

  localparam int SYNC = 2;
  localparam int DBC  = 4;
`ifdef SOC_PIO_IN_DEBOUNCE_EN
  localparam int L    = SYNC + DBC;
  localparam int HOLD = DBC + 2;
`else
  localparam int L    = SYNC;
  localparam int HOLD = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in8 = 8'h00;
  logic [31:0] in32 = 32'd0;
  logic [31:0] rd8, rd32;
  logic        irq8, irq32;

  int checks = 0;
  int errors = 0;

  soc_pio_in_capture #(
    .DATA_WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd8), .in_port(in8), .irq(irq8)
  );

  soc_pio_in_capture #(
    .DATA_WIDTH(32), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DBC)
  ) dut32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd32), .in_port(in32), .irq(irq32)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (L + 3) tick();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // ------------------------------------------------ behavioural model (dut)
  logic [7:0]  m_f, m_prev, m_mask, m_cap;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [7:0]  m_hist[$];

  task automatic model_reset();
    m_f = '0; m_prev = '0; m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
    m_hist.delete();
  endtask

  // Advance the model across one clock edge using the inputs driven now.
  task automatic model_step();
    logic [7:0]  rises, clr, nf;
    logic [31:0] nrd;
    rises = m_f & ~m_prev;
    clr   = (chipselect && write && address == 2'd3) ? writedata[7:0] : 8'h00;
    case (address)
      2'd0:    nrd = {24'd0, m_f};
      2'd1:    nrd = {24'd0, m_mask};
      2'd3:    nrd = {24'd0, m_cap};
      default: nrd = 32'd0;
    endcase
    m_irq = (m_cap & m_mask) != 8'h00;
    if (chipselect && write && address == 2'd1) m_mask = writedata[7:0];
    m_cap = (m_cap & ~clr) | rises;
    // The filtered level is the input as it was L clocks ago.
    m_hist.push_back(in8);
    if (m_hist.size() > L) void'(m_hist.pop_front());
    nf = (m_hist.size() == L) ? m_hist[0] : 8'h00;
    m_prev = m_f;
    m_f    = nf;
    m_rd   = nrd;
  endtask

  // ------------------------------------------------ directed vector table
  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  in;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int hold_cnt;

    vecs[0]  = '{"lvl_3c",        2'd0, 1'b0, 1'b0, 32'h0,        8'h3C, 32'h3C, 1'b0};
    vecs[1]  = '{"rsvd_rd_wr",    2'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 8'h3C, 32'h00, 1'b0};
    vecs[2]  = '{"cap_3c",        2'd3, 1'b0, 1'b0, 32'h0,        8'h3C, 32'h3C, 1'b0};
    vecs[3]  = '{"mask_wr_hi",    2'd1, 1'b1, 1'b1, 32'hFFFFFF04, 8'h3C, 32'h04, 1'b1};
    vecs[4]  = '{"w1c_bit2",      2'd3, 1'b1, 1'b1, 32'h04,       8'h3C, 32'h38, 1'b0};
    vecs[5]  = '{"w1c_no_cs",     2'd3, 1'b0, 1'b1, 32'hFF,       8'h3C, 32'h38, 1'b0};
    vecs[6]  = '{"data_wr_ign",   2'd0, 1'b1, 1'b1, 32'hFF,       8'h3C, 32'h3C, 1'b0};
    vecs[7]  = '{"w1c_all",       2'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 8'h3C, 32'h00, 1'b0};
    vecs[8]  = '{"rise_c3",       2'd3, 1'b0, 1'b0, 32'h0,        8'hC3, 32'hC3, 1'b0};
    vecs[9]  = '{"rise_bit2_irq", 2'd3, 1'b0, 1'b0, 32'h0,        8'hC7, 32'hC7, 1'b1};
    vecs[10] = '{"unmask",        2'd1, 1'b1, 1'b1, 32'h0,        8'hC7, 32'h00, 1'b0};
    vecs[11] = '{"cap_kept",      2'd3, 1'b0, 1'b0, 32'h0,        8'hC7, 32'hC7, 1'b0};
    vecs[12] = '{"lvl_00",        2'd0, 1'b0, 1'b0, 32'h0,        8'h00, 32'h00, 1'b0};
    vecs[13] = '{"fall_ignored",  2'd3, 1'b0, 1'b0, 32'h0,        8'h00, 32'hC7, 1'b0};

    // ---- reset held with inputs active, then release timing
    in8 = 8'hA5;
    address = 2'd0;
    repeat (4) begin
      tick();
      check("rst_rd", rd8, 32'h0);
      check("rst_irq", {31'd0, irq8}, 32'h0);
    end
    reset = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      check($sformatf("rst_release_rd_k%0d", k), rd8, (k == L + 1) ? 32'hA5 : 32'h0);
    end

    // ---- vector table
    in8 = 8'h00;
    do_reset();
    settle();
    for (int i = 0; i < 14; i++) begin
      address    = vecs[i].addr;
      chipselect = vecs[i].cs;
      write      = vecs[i].wr;
      writedata  = vecs[i].wd;
      in8        = vecs[i].in;
      settle();
      check({vecs[i].name, "_rd"}, rd8, vecs[i].exp_rd);
      check({vecs[i].name, "_irq"}, {31'd0, irq8}, {31'd0, vecs[i].exp_irq});
    end
    bus_idle();

    // ---- asynchronous reset mid-cycle clears registers without a clock edge
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_rd", rd8, 32'h0);
    check("async_rst_irq", {31'd0, irq8}, 32'h0);

    // ---- level read latency
    in8 = 8'h00;
    do_reset();
    settle();
    address = 2'd0;
    in8 = 8'h3C;
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      check($sformatf("lvl_lat_k%0d", k), rd8, (k == L + 1) ? 32'h3C : 32'h0);
    end
    bus_write(2'd2, 32'hFFFFFFFF);
    tick();
    check("rsvd_reads_0", rd8, 32'h0);

    // ---- edge capture and irq latency
    in8 = 8'h00;
    settle();
    bus_write(2'd1, 32'h1);
    bus_write(2'd3, 32'hFFFFFFFF);
    address = 2'd3;
    settle();
    in8 = 8'h01;
    for (int k = 1; k <= L + 2; k++) begin
      tick();
      check($sformatf("cap_lat_k%0d", k), rd8, (k >= L + 2) ? 32'h1 : 32'h0);
      check($sformatf("irq_lat_k%0d", k), {31'd0, irq8}, (k >= L + 2) ? 32'h1 : 32'h0);
    end

    // ---- W1C clears irq two edges after the write is presented
    bus_write(2'd3, 32'h1);
    check("w1c_irq_e1", {31'd0, irq8}, 32'h1);
    tick();
    check("w1c_irq_e2", {31'd0, irq8}, 32'h0);
    check("w1c_rd_e2", rd8, 32'h0);

    // ---- set/clear collision on bit 0
    in8 = 8'h00;
    settle();
    in8 = 8'h01;
    settle();
    in8 = 8'h00;
    settle();
    check("coll_pre_irq", {31'd0, irq8}, 32'h1);
    in8 = 8'h01;
    repeat (L) tick();
    bus_write(2'd3, 32'h1);
    check("coll_irq_e1", {31'd0, irq8}, 32'h1);
    for (int k = 2; k <= 3; k++) begin
      tick();
      check($sformatf("coll_rd_k%0d", k), rd8, 32'h1);
      check($sformatf("coll_irq_k%0d", k), {31'd0, irq8}, 32'h1);
    end

    // ---- 32-bit any-edge instance
    in8 = 8'h00;
    in32 = 32'h0;
    do_reset();
    address = 2'd0;
    in32 = 32'hDEADBEEF;
    settle();
    check("w32_level", rd32, 32'hDEADBEEF);
    in32 = 32'h80000000;
    settle();
    bus_write(2'd3, 32'hFFFFFFFF);
    address = 2'd3;
    settle();
    check("w32_cap_cleared", rd32, 32'h0);
    in32 = 32'h0;
    settle();
    check("w32_fall_cap", rd32, 32'h80000000);
    check("w32_irq_unmasked", {31'd0, irq32}, 32'h0);

    // ---- randomized traffic against the model
    in8 = 8'h00;
    do_reset();
    model_reset();
    hold_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold_cnt == 0) begin
        in8 = 8'($urandom);
        hold_cnt = HOLD;
      end
      hold_cnt--;
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 2) == 0);
      writedata  = $urandom;
      model_step();
      tick();
      check($sformatf("rnd_rd_n%0d", n), rd8, m_rd);
      check($sformatf("rnd_irq_n%0d", n), {31'd0, irq8}, {31'd0, m_irq});
    end
    bus_idle();

`ifdef SOC_PIO_IN_DEBOUNCE_EN
    // ---- debounce: short glitch rejected, long pulse passes with exact delay
    in8 = 8'h00;
    do_reset();
    settle();
    address = 2'd0;
    in8 = 8'h04;
    for (int k = 1; k <= L + 4; k++) begin
      tick();
      if (k == DBC - 1) in8 = 8'h00;
      check($sformatf("dbc_glitch_rd_k%0d", k), rd8, 32'h0);
    end
    address = 2'd3;
    settle();
    check("dbc_glitch_cap", rd8, 32'h0);
    address = 2'd0;
    in8 = 8'h04;
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      if (k == DBC + 1) in8 = 8'h00;
      check($sformatf("dbc_pulse_rd_k%0d", k), rd8, (k == L + 1) ? 32'h04 : 32'h0);
    end
    address = 2'd3;
    settle();
    check("dbc_pulse_cap", rd8, 32'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
